qsram_sdr_ctrl: RTL and testbench
=================================

# qsram_sdr_ctrl

Parametrised synchronous single-data-rate QSRAM block, the next generation of the team's QSRAM macro. Separate write and read data buses replace the bidirectional data port. Adds a configurable read pipeline, an internal refresh scheduler with a blocking window, and command-status outputs. It sits between the system bus master and the on-board QSRAM storage and is the only agent that sequences refresh.

## Interface
- ADDR_WIDTH, 10, address bits; depth = 2**ADDR_WIDTH words
- DATA_WIDTH, 9, word width in bits
- READ_LATENCY, 2, cycles from accepted read to ReadValid; legal range 1..4
- REFRESH_INTERVAL, 64, cycles between automatic refreshes; must be ≥ REFRESH_CYCLES+2
- REFRESH_CYCLES, 4, length of the refresh blocking window in cycles
- Clock  in  1  single clock; all logic on the rising edge
- Reset  in  1  synchronous, active-high reset
- Enable  in  1  command strobe, sampled every cycle
- Read  in  1  read command qualifier
- Write  in  1  write command qualifier
- Refresh  in  1  forced refresh request, single-cycle pulse
- Address  in  ADDR_WIDTH  word address
- WriteData  in  DATA_WIDTH  write data, sampled with the write command
- ReadData  out  DATA_WIDTH  read data; holds its last value between reads
- ReadValid  out  1  one-cycle pulse marking valid ReadData
- Busy  out  1  high while the block is in REFRESH
- CmdDropped  out  1  one-cycle pulse: command arrived while Busy
- CmdError  out  1  one-cycle pulse: Read and Write both set with Enable

## Operation
- Accepted command: Enable=1 & Busy=0 & exactly one of Read/Write set.
- Write: mem[Address] <= WriteData at the accepting edge.
- Read: mem[Address] is sampled at the accepting edge and travels down the READ_LATENCY-stage pipeline. One read can be accepted per cycle, so back-to-back reads give back-to-back ReadValid pulses.
- Read of an address written in an earlier cycle returns the new data. There is no same-cycle read/write, because that combination is CmdError.
- Enable=1 with Read=Write=0: no-op, no flags.
- Enable=1 with Read=Write=1 and Busy=0: no memory access; CmdError pulses 1 cycle later.
- Enable=1 with any Read/Write while Busy=1: no access; CmdDropped pulses 1 cycle later. CmdError is not raised in this case.
- FSM states:
  - RUN: the interval counter increments each cycle. Go to REFRESH when the counter reaches REFRESH_INTERVAL-1, or when Refresh=1.
  - REFRESH: the window counter runs for REFRESH_CYCLES cycles, then the FSM returns to RUN. Busy is high for exactly REFRESH_CYCLES cycles. The interval counter clears on entry to REFRESH.
- A Refresh pulse while in REFRESH is ignored and does not extend the window.
- A Refresh pulse in the same cycle as an accepted command: the command is executed, because Busy is still 0 in that cycle. REFRESH starts on the next cycle.
- Reads already in the pipeline when REFRESH begins complete normally.
- Memory contents are not initialised by Reset.

## Timing
- Reset values: ReadData=0, ReadValid=0, Busy=0, CmdDropped=0, CmdError=0. FSM returns to RUN, both counters to 0, read pipeline valid bits to 0.
- Reset mid-operation: in-flight reads are discarded and produce no ReadValid. Writes accepted before the Reset edge persist.
- Read accepted at edge N: ReadValid=1 and ReadData valid in the cycle after edge N+READ_LATENCY-1. For READ_LATENCY=1, they appear after edge N.
- Busy rises the cycle after the triggering edge. It stays high for REFRESH_CYCLES cycles.
- With no forced refreshes, automatic refreshes repeat every REFRESH_INTERVAL+REFRESH_CYCLES cycles.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package qsram_pkg holds:
  - the state enum (RUN, REFRESH)
  - READ_LATENCY bounds constants
  - a helper function for counter width, clog2 of REFRESH_INTERVAL
- Sub-module qsram_read_pipe: a parametrised valid/data shift register of depth READ_LATENCY, with a synchronous clear. It is used once.
- The top level holds the storage array, the FSM, both counters and the flag registers. Target size is about 200 lines.

## Test plan
- Write-then-read, READ_LATENCY=2: write 0x1A5 to address 3 then 0x0F0 to address 4; read 3, 4 back-to-back. Required: ReadValid on two consecutive cycles, data 0x1A5 then 0x0F0, first pulse 2 cycles after acceptance.
- Auto refresh, REFRESH_INTERVAL=64, REFRESH_CYCLES=4: idle from reset. Required: Busy high during cycles 64–67, then again during 132–135.
- Forced refresh plus drop: Refresh pulse, then a write to address 5 on the next cycle. Required: Busy=1, CmdDropped pulses once, and a later read of address 5 returns its old value.
- Illegal command: Enable=Read=Write=1. Required: CmdError pulses for 1 cycle, no ReadValid, memory unchanged.
- Reset mid-read, READ_LATENCY=4: issue a read, then assert Reset 2 cycles later. Required: no ReadValid, all outputs 0, previously written data still readable afterwards.
- Refresh with a pipeline in flight: a read is accepted in the same cycle as a Refresh pulse. Required: the read executes, ReadValid arrives on schedule while Busy=1.

Source files
------------

// File: rtl/qsram_pkg.sv
// Shared types and constants for the QSRAM SDR controller.
package qsram_pkg;

   // Controller operating state.
   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_REFRESH = 1'b1
   } state_t;

   // Legal range for the read pipeline depth.
   localparam int READ_LATENCY_MIN = 1;
   localparam int READ_LATENCY_MAX = 4;

   // Bits needed for a counter that runs 0 .. count-1 (never less than one bit).
   function automatic int cnt_width(input int count);
      return (count > 2) ? $clog2(count) : 1;
   endfunction

endpackage

// File: rtl/qsram_read_pipe.sv
// Valid/data shift register carrying read words to the output.
// Stage 0 captures the array word, so it doubles as the RAM output register.
module qsram_read_pipe #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   logic [DEPTH-1:0] valid_reg;
   logic [WIDTH-1:0] data_reg [DEPTH];

   // Shift valid every cycle; data only moves with its valid so the last
   // stage holds the most recent read word between reads.
   always_ff @(posedge clk) begin
      if (srst) begin
         valid_reg <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_reg[i] <= '0;
         end
      end else begin
         valid_reg[0] <= in_valid;
         if (in_valid) begin
            data_reg[0] <= in_data;
         end
         for (int i = 1; i < DEPTH; i++) begin
            valid_reg[i] <= valid_reg[i-1];
            if (valid_reg[i-1]) begin
               data_reg[i] <= data_reg[i-1];
            end
         end
      end
   end

   assign out_valid = valid_reg[DEPTH-1];
   assign out_data  = data_reg[DEPTH-1];

endmodule

// File: rtl/qsram_sdr_ctrl.sv
// QSRAM SDR controller: storage array, refresh scheduler FSM, read pipeline
// and registered command-status flags.
module qsram_sdr_ctrl
   import qsram_pkg::*;
#(
   parameter int ADDR_WIDTH       = 10,
   parameter int DATA_WIDTH       = 9,
   parameter int READ_LATENCY     = 2,
   parameter int REFRESH_INTERVAL = 64,
   parameter int REFRESH_CYCLES   = 4
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Enable,
   input  logic                  Read,
   input  logic                  Write,
   input  logic                  Refresh,
   input  logic [ADDR_WIDTH-1:0] Address,
   input  logic [DATA_WIDTH-1:0] WriteData,
   output logic [DATA_WIDTH-1:0] ReadData,
   output logic                  ReadValid,
   output logic                  Busy,
   output logic                  CmdDropped,
   output logic                  CmdError
);

   localparam int ICW = cnt_width(REFRESH_INTERVAL);
   localparam int WCW = cnt_width(REFRESH_CYCLES);
   localparam logic [ICW-1:0] INTERVAL_LAST = ICW'(REFRESH_INTERVAL - 1);
   localparam logic [WCW-1:0] WINDOW_LAST   = WCW'(REFRESH_CYCLES - 1);

   // Reject parameter sets the scheduler and pipeline cannot honour.
   if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_latency
      $error("qsram_sdr_ctrl: READ_LATENCY out of range");
   end
   if (REFRESH_INTERVAL < REFRESH_CYCLES + 2) begin : g_bad_interval
      $error("qsram_sdr_ctrl: REFRESH_INTERVAL too short");
   end

   state_t           state_reg, state_next;
   logic [ICW-1:0]   interval_cnt_reg, interval_cnt_next;
   logic [WCW-1:0]   window_cnt_reg, window_cnt_next;
   logic             cmd_error_reg, cmd_dropped_reg;
   logic             busy;
   logic             one_cmd;
   logic             rd_accept, wr_accept;
   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] rd_word;

   // Busy comes straight from the state register, so it is glitch-free and
   // a forced refresh in this cycle cannot block a command in this cycle.
   assign busy      = (state_reg == ST_REFRESH);
   assign one_cmd   = Read ^ Write;
   assign rd_accept = Enable & ~busy & one_cmd & Read;
   assign wr_accept = Enable & ~busy & one_cmd & Write;
   assign rd_word   = mem[Address];

   // Storage writes; contents survive reset, and nothing is written while reset is held.
   always_ff @(posedge Clock) begin
      if (!Reset && wr_accept) begin
         mem[Address] <= WriteData;
      end
   end

   // Scheduler state and counters.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_reg        <= ST_RUN;
         interval_cnt_reg <= '0;
         window_cnt_reg   <= '0;
      end else begin
         state_reg        <= state_next;
         interval_cnt_reg <= interval_cnt_next;
         window_cnt_reg   <= window_cnt_next;
      end
   end

   // Next-state logic: RUN counts toward the next refresh, REFRESH times the window.
   always_comb begin
      state_next        = state_reg;
      interval_cnt_next = interval_cnt_reg;
      window_cnt_next   = window_cnt_reg;
      case (state_reg)
         ST_RUN: begin
            if (Refresh || (interval_cnt_reg == INTERVAL_LAST)) begin
               state_next        = ST_REFRESH;
               interval_cnt_next = '0;
               window_cnt_next   = '0;
            end else begin
               interval_cnt_next = interval_cnt_reg + ICW'(1);
            end
         end
         ST_REFRESH: begin
            // A Refresh pulse here is deliberately ignored.
            if (window_cnt_reg == WINDOW_LAST) begin
               state_next      = ST_RUN;
               window_cnt_next = '0;
            end else begin
               window_cnt_next = window_cnt_reg + WCW'(1);
            end
         end
         default: begin
            state_next        = ST_RUN;
            interval_cnt_next = '0;
            window_cnt_next   = '0;
         end
      endcase
   end

   // Command-status pulses, one cycle after the offending command.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         cmd_error_reg   <= 1'b0;
         cmd_dropped_reg <= 1'b0;
      end else begin
         cmd_error_reg   <= Enable & Read & Write & ~busy;
         cmd_dropped_reg <= Enable & (Read | Write) & busy;
      end
   end

   qsram_read_pipe #(
      .DEPTH (READ_LATENCY),
      .WIDTH (DATA_WIDTH)
   ) u_read_pipe (
      .clk       (Clock),
      .srst      (Reset),
      .in_valid  (rd_accept),
      .in_data   (rd_word),
      .out_valid (ReadValid),
      .out_data  (ReadData)
   );

   assign Busy       = busy;
   assign CmdError   = cmd_error_reg;
   assign CmdDropped = cmd_dropped_reg;

endmodule

// File: tb/tb_qsram_sdr_ctrl.sv
// Self-checking bench for qsram_sdr_ctrl: directed table, corner sequences,
// and randomized traffic against a cycle-indexed reference model.
module tb_qsram_sdr_ctrl;

   localparam int AW  = 10;
   localparam int DW  = 9;
   localparam int LAT = 2;
   localparam int RI  = 64;
   localparam int RC  = 4;

   logic          clk = 1'b0;
   logic          Reset = 1'b1;
   logic          Enable = 1'b0, Read = 1'b0, Write = 1'b0, Refresh = 1'b0;
   logic [AW-1:0] Address = '0;
   logic [DW-1:0] WriteData = '0;
   logic [DW-1:0] ReadData;
   logic          ReadValid, Busy, CmdDropped, CmdError;

   qsram_sdr_ctrl #(
      .ADDR_WIDTH       (AW),
      .DATA_WIDTH       (DW),
      .READ_LATENCY     (LAT),
      .REFRESH_INTERVAL (RI),
      .REFRESH_CYCLES   (RC)
   ) dut (
      .Clock      (clk),
      .Reset      (Reset),
      .Enable     (Enable),
      .Read       (Read),
      .Write      (Write),
      .Refresh    (Refresh),
      .Address    (Address),
      .WriteData  (WriteData),
      .ReadData   (ReadData),
      .ReadValid  (ReadValid),
      .Busy       (Busy),
      .CmdDropped (CmdDropped),
      .CmdError   (CmdError)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // ---------------- reference model ----------------
   // Time is an absolute cycle index; refresh windows are absolute ranges.
   typedef struct {
      int            due;
      logic [DW-1:0] data;
      bit            known;
   } rd_t;

   rd_t           rq[$];
   logic [DW-1:0] mem_m   [2**AW];
   bit            known_m [2**AW];
   int            cyc = 0;
   int            rs = -1;          // first busy cycle of the latest window
   int            run_start = 0;    // cycle at which the interval count was zero
   logic [DW-1:0] m_data = '0;
   bit            m_data_known = 1'b1;
   bit            m_valid = 1'b0, m_err = 1'b0, m_drop = 1'b0;

   function automatic bit m_busy(input int c);
      return (rs >= 0) && (c >= rs) && (c < rs + RC);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
      end
   endtask

   // Drive one cycle of inputs, advance the model across the edge, compare all outputs.
   task automatic step(input bit rst, input bit en, input bit rd, input bit wr,
                       input bit rf, input int a, input int d);
      bit busy_c;
      Reset = rst; Enable = en; Read = rd; Write = wr; Refresh = rf;
      Address = AW'(a); WriteData = DW'(d);
      busy_c = m_busy(cyc);
      @(posedge clk);
      if (rst) begin
         rq.delete();
         m_data = '0; m_data_known = 1'b1;
         m_err = 1'b0; m_drop = 1'b0;
         rs = -1; run_start = cyc + 1;
      end else begin
         m_err  = en && rd && wr && !busy_c;
         m_drop = en && (rd || wr) && busy_c;
         if (en && !busy_c && (rd != wr)) begin
            if (wr) begin
               mem_m[a] = DW'(d); known_m[a] = 1'b1;
            end else begin
               rq.push_back('{cyc + LAT, mem_m[a], known_m[a]});
            end
         end
         if (!busy_c && (rf || (cyc - run_start == RI - 1))) begin
            rs = cyc + 1;
            run_start = cyc + 1 + RC;
         end
      end
      cyc++;
      #1;
      m_valid = 1'b0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
         m_valid = 1'b1;
         m_data = rq[0].data;
         m_data_known = rq[0].known;
         void'(rq.pop_front());
      end
      check("model_valid", 32'(ReadValid), 32'(m_valid));
      if (m_data_known) check("model_data", 32'(ReadData), 32'(m_data));
      check("model_busy", 32'(Busy), 32'(m_busy(cyc)));
      check("model_err", 32'(CmdError), 32'(m_err));
      check("model_drop", 32'(CmdDropped), 32'(m_drop));
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0);
   endtask

   // Issue a read and wait (bounded) for its pulse; check latency and data.
   task automatic read_expect(input string name, input int a, input int exp, input bit rf);
      int n;
      step(0, 1, 1, 0, rf, a, 0);
      n = 1;
      while (!ReadValid && n < LAT + 3) begin
         idle();
         n++;
      end
      check({name, "_latency"}, 32'(n), 32'(LAT));
      check({name, "_valid"}, 32'(ReadValid), 32'd1);
      check({name, "_data"}, 32'(ReadData), 32'(exp));
      $display("read %s addr=%0d data=0x%0h after %0d cycles", name, a, ReadData, n);
   endtask

   typedef struct {
      bit en, rd, wr, rf;
      int addr, wd;
      bit valid;
      int data;
      bit busy, err, drop;
   } vec_t;

   function automatic int prefill(input int a);
      return (a * 37 + 5) & 'h1FF;
   endfunction

   initial begin
      vec_t tbl[12];
      int   busy_cnt;
      bit   any_valid;

      tbl[0]  = '{1, 0, 1, 0, 3, 'h1A5, 0, 'h000, 0, 0, 0};
      tbl[1]  = '{1, 0, 1, 0, 4, 'h0F0, 0, 'h000, 0, 0, 0};
      tbl[2]  = '{1, 1, 0, 0, 3, 0,     0, 'h000, 0, 0, 0};
      tbl[3]  = '{1, 1, 0, 0, 4, 0,     1, 'h1A5, 0, 0, 0};
      tbl[4]  = '{0, 0, 0, 0, 0, 0,     1, 'h0F0, 0, 0, 0};
      tbl[5]  = '{0, 0, 0, 0, 0, 0,     0, 'h0F0, 0, 0, 0};
      tbl[6]  = '{1, 1, 1, 0, 3, 'h055, 0, 'h0F0, 0, 1, 0};
      tbl[7]  = '{1, 1, 0, 0, 3, 0,     0, 'h0F0, 0, 0, 0};
      tbl[8]  = '{0, 0, 0, 0, 0, 0,     1, 'h1A5, 0, 0, 0};
      tbl[9]  = '{0, 0, 0, 0, 0, 0,     0, 'h1A5, 0, 0, 0};
      tbl[10] = '{1, 0, 0, 0, 3, 0,     0, 'h1A5, 0, 0, 0};
      tbl[11] = '{0, 0, 0, 0, 0, 0,     0, 'h1A5, 0, 0, 0};

      for (int i = 0; i < 2**AW; i++) begin
         mem_m[i] = '0; known_m[i] = 1'b0;
      end

      // Reset state.
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);
      check("rst_data", 32'(ReadData), 32'd0);
      check("rst_valid", 32'(ReadValid), 32'd0);
      check("rst_busy", 32'(Busy), 32'd0);
      check("rst_err", 32'(CmdError), 32'd0);
      check("rst_drop", 32'(CmdDropped), 32'd0);

      // Automatic refresh from reset: Busy over cycles 64-67 and 132-135.
      for (int i = 1; i <= 140; i++) begin
         idle();
         check("auto_busy", 32'(Busy),
               32'(((i >= 64) && (i <= 67)) || ((i >= 132) && (i <= 135))));
      end
      $display("auto refresh sequence done");

      // Fresh reset, then known contents in addresses 0..31.
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      for (int a = 0; a < 32; a++) step(0, 1, 0, 1, 0, a, prefill(a));

      // Table: write-then-read, illegal command, Enable-only no-op.
      for (int i = 0; i < 12; i++) begin
         step(0, tbl[i].en, tbl[i].rd, tbl[i].wr, tbl[i].rf, tbl[i].addr, tbl[i].wd);
         check("tbl_valid", 32'(ReadValid), 32'(tbl[i].valid));
         check("tbl_data", 32'(ReadData), 32'(tbl[i].data));
         check("tbl_busy", 32'(Busy), 32'(tbl[i].busy));
         check("tbl_err", 32'(CmdError), 32'(tbl[i].err));
         check("tbl_drop", 32'(CmdDropped), 32'(tbl[i].drop));
         $display("vec %0d en=%0d rd=%0d wr=%0d addr=%0d -> valid=%0d data=0x%0h err=%0d",
                  i, tbl[i].en, tbl[i].rd, tbl[i].wr, tbl[i].addr, ReadValid, ReadData, CmdError);
      end

      // Forced refresh, dropped write, ignored second Refresh.
      step(0, 0, 0, 0, 1, 0, 0);
      check("frc_busy_rise", 32'(Busy), 32'd1);
      busy_cnt = 1;
      step(0, 1, 0, 1, 0, 5, 'h1FF);
      check("frc_drop", 32'(CmdDropped), 32'd1);
      check("frc_drop_noerr", 32'(CmdError), 32'd0);
      busy_cnt += int'(Busy);
      step(0, 0, 0, 0, 1, 0, 0);
      check("frc_drop_once", 32'(CmdDropped), 32'd0);
      busy_cnt += int'(Busy);
      for (int i = 0; i < 8; i++) begin
         idle();
         busy_cnt += int'(Busy);
      end
      check("frc_window_len", 32'(busy_cnt), 32'(RC));
      read_expect("frc_old5", 5, prefill(5), 1'b0);

      // Reset while a read is in flight.
      step(0, 1, 0, 1, 0, 6, 'h123);
      step(0, 1, 1, 0, 0, 3, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      check("rstmid_valid", 32'(ReadValid), 32'd0);
      check("rstmid_data", 32'(ReadData), 32'd0);
      check("rstmid_busy", 32'(Busy), 32'd0);
      any_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         idle();
         any_valid |= ReadValid;
      end
      check("rstmid_novalid", 32'(any_valid), 32'd0);
      read_expect("rstmid_a3", 3, 'h1A5, 1'b0);
      read_expect("rstmid_a6", 6, 'h123, 1'b0);

      // Read accepted together with a forced refresh completes while Busy.
      read_expect("inflt", 4, 'h0F0, 1'b1);
      check("inflt_busy", 32'(Busy), 32'd1);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom % 400) == 0, ($urandom % 4) != 0, $urandom % 2, $urandom % 2,
              ($urandom % 50) == 0, int'($urandom % 32), int'($urandom % 512));
      end
      $display("random phase done at cycle %0d", cyc);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
